// File: rtl/sar_adc_pkg.sv
// Shared types and default parameters for the SAR ADC controller.
// Pure definitions: no logic, no latency, no flow control.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BLANK,
    ST_SAMPLE,
    ST_CONVERT
  } sar_state_t;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_BLANK_CYCLES  = 8;

endpackage

// File: rtl/sar_phase_counter.sv
// Loadable down-counter that times the track phase and each per-bit DAC settle.
// tc is high while the count is 0; load N-1 for an N-cycle phase. No backpressure.
module sar_phase_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC sequencer with LED-switch blanking; result 1+SAMPLE+DATA_W*SETTLE cycles after start.
// start while busy is dropped with a one-cycle overrun pulse; nothing is queued.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              led_sel,
  input  logic              comp_in,
  output logic              sample_hold,
  output logic [DATA_W-1:0] dac_code,
  output logic [DATA_W-1:0] V_ADC,
  output logic              adc_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int IDX_W  = $clog2(DATA_W);
  localparam int BLK_W  = $clog2(BLANK_CYCLES + 1);
  localparam int PH_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]   SAMPLE_LD = PH_W'(SAMPLE_CYCLES - 1);
  localparam logic [PH_W-1:0]   SETTLE_LD = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [BLK_W-1:0]  BLANK_LD  = BLK_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  MSB_IDX   = IDX_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MSB_BIT   = {1'b1, {(DATA_W-1){1'b0}}};

  sar_state_t        state;
  logic              led_prev;
  logic              led_edge;
  logic [BLK_W-1:0]  blank_cnt;
  logic [BLK_W-1:0]  blank_next;
  logic              idle_go;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] bit_kept;
  logic [DATA_W-1:0] next_trial;
  logic              ph_load;
  logic [PH_W-1:0]   ph_val;
  logic              ph_tc;

  assign led_edge   = (led_sel != led_prev);
  assign blank_next = led_edge ? BLANK_LD : ((blank_cnt != '0) ? blank_cnt - 1'b1 : '0);
  assign idle_go    = (blank_cnt == '0) && !led_edge;

  // result holds the decided upper bits with the trial bit clear, so a
  // rejected bit simply falls back to result.
  assign bit_kept   = comp_in ? dac_code : result;
  assign next_trial = bit_kept | (DATA_W'(1) << (bit_idx - 1'b1));

  always_comb begin
    ph_load = 1'b0;
    ph_val  = SAMPLE_LD;
    case (state)
      ST_IDLE:       ph_load = start && idle_go;
      ST_WAIT_BLANK: ph_load = (blank_next == '0);
      ST_SAMPLE, ST_CONVERT: begin
        if (!led_edge && ph_tc) begin
          ph_load = 1'b1;
          ph_val  = SETTLE_LD;
        end
      end
      default: ph_load = 1'b0;
    endcase
  end

  sar_phase_counter #(
    .W(PH_W)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .tc       (ph_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      led_prev    <= led_sel;
      blank_cnt   <= BLANK_LD;
      bit_idx     <= '0;
      result      <= '0;
      sample_hold <= 1'b0;
      dac_code    <= '0;
      V_ADC       <= '0;
      adc_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      led_prev  <= led_sel;
      blank_cnt <= blank_next;
      adc_valid <= 1'b0;
      overrun   <= start && busy;

      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (idle_go) begin
              state       <= ST_SAMPLE;
              sample_hold <= 1'b1;
            end else begin
              state <= ST_WAIT_BLANK;
            end
          end
        end

        ST_WAIT_BLANK: begin
          if (blank_next == '0) begin
            state       <= ST_SAMPLE;
            sample_hold <= 1'b1;
          end
        end

        ST_SAMPLE, ST_CONVERT: begin
          if (led_edge) begin
            // LED transient: drop the partial result and resample after blanking
            state       <= ST_WAIT_BLANK;
            sample_hold <= 1'b0;
            dac_code    <= '0;
            result      <= '0;
          end else if (ph_tc) begin
            if (state == ST_SAMPLE) begin
              state       <= ST_CONVERT;
              sample_hold <= 1'b0;
              bit_idx     <= MSB_IDX;
              result      <= '0;
              dac_code    <= MSB_BIT;
            end else if (bit_idx == '0) begin
              state     <= ST_IDLE;
              V_ADC     <= bit_kept;
              adc_valid <= 1'b1;
              dac_code  <= '0;
              result    <= '0;
              busy      <= 1'b0;
            end else begin
              result   <= bit_kept;
              bit_idx  <= bit_idx - 1'b1;
              dac_code <= next_trial;
            end
          end
        end

        default: begin
          state       <= ST_IDLE;
          sample_hold <= 1'b0;
          dac_code    <= '0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed self-checking bench for sar_adc_ctrl with a behavioural comparator.
// Window k = k-th falling edge after the edge that sampled start (cycle t+k).
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       led_sel = 1'b0;
  logic [7:0] ain = 8'hFF;
  logic       comp_in;
  logic       sample_hold;
  logic [7:0] dac_code;
  logic [7:0] V_ADC;
  logic       adc_valid;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ideal comparator: held input at or above the DAC voltage
  assign comp_in = (dac_code <= ain);

  sar_adc_ctrl #(
    .DATA_W(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2), .BLANK_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .led_sel(led_sel), .comp_in(comp_in),
    .sample_hold(sample_hold), .dac_code(dac_code), .V_ADC(V_ADC),
    .adc_valid(adc_valid), .busy(busy), .overrun(overrun)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sample_hold !== 1'b0) begin errors++; $display("FAIL rst_sh got=%b exp=0", sample_hold); end
    checks++; if (dac_code !== 8'h00) begin errors++; $display("FAIL rst_dac got=%h exp=00", dac_code); end
    checks++; if (V_ADC !== 8'h00) begin errors++; $display("FAIL rst_vadc got=%h exp=00", V_ADC); end
    checks++; if (adc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", adc_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    rst = 1'b0;
    idle(12);
  endtask

  task automatic test_conversion;
    logic [7:0]  av [2];
    logic [63:0] dv [2];
    logic [7:0]  rv [2];
    logic [7:0]  v_old;
    logic [7:0]  exp_d;
    av = '{8'hFF, 8'h5A};
    dv = '{64'h80C0E0F0F8FCFEFF, 64'h804060505_85C5A5B};
    rv = '{8'hFF, 8'h5A};
    for (int v = 0; v < 2; v++) begin
      ain   = av[v];
      v_old = V_ADC;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 22; k++) begin
        if (k <= 4) begin
          checks++; if (sample_hold !== 1'b1 || dac_code !== 8'h00) begin
            errors++; $display("FAIL conv%0d_track k=%0d sh=%b dac=%h exp sh=1 dac=00", v, k, sample_hold, dac_code); end
        end else begin
          checks++; if (sample_hold !== 1'b0) begin
            errors++; $display("FAIL conv%0d_hold k=%0d got=%b exp=0", v, k, sample_hold); end
        end
        if (k >= 5 && k <= 20) begin
          exp_d = 8'(dv[v] >> (8 * (7 - (k - 5) / 2)));
          checks++; if (dac_code !== exp_d) begin
            errors++; $display("FAIL conv%0d_dac k=%0d got=%h exp=%h", v, k, dac_code, exp_d); end
        end
        if (k == 21) begin
          checks++; if (adc_valid !== 1'b1 || V_ADC !== rv[v] || busy !== 1'b0 || dac_code !== 8'h00) begin
            errors++; $display("FAIL conv%0d_done valid=%b vadc=%h busy=%b dac=%h exp 1/%h/0/00", v, adc_valid, V_ADC, busy, dac_code, rv[v]); end
        end else begin
          checks++; if (adc_valid !== 1'b0) begin
            errors++; $display("FAIL conv%0d_valid k=%0d got=%b exp=0", v, k, adc_valid); end
          if (k < 21) begin
            checks++; if (V_ADC !== v_old || busy !== 1'b1) begin
              errors++; $display("FAIL conv%0d_stable k=%0d vadc=%h busy=%b exp %h/1", v, k, V_ADC, busy, v_old); end
          end
        end
        @(negedge clk);
      end
      idle(2);
    end
  endtask

  task automatic test_back_to_back;
    ain   = 8'h81;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      if (k == 21) begin
        checks++; if (adc_valid !== 1'b1 || V_ADC !== 8'h81) begin
          errors++; $display("FAIL b2b_first valid=%b vadc=%h exp 1/81", adc_valid, V_ADC); end
        start = 1'b1;
        ain   = 8'h3C;
      end else if (k == 42) begin
        checks++; if (adc_valid !== 1'b1 || V_ADC !== 8'h3C) begin
          errors++; $display("FAIL b2b_second valid=%b vadc=%h exp 1/3C", adc_valid, V_ADC); end
      end else begin
        checks++; if (adc_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_valid k=%0d got=%b exp=0", k, adc_valid); end
      end
      if (k == 22) begin
        start = 1'b0;
        checks++; if (busy !== 1'b1 || sample_hold !== 1'b1 || overrun !== 1'b0) begin
          errors++; $display("FAIL b2b_accept busy=%b sh=%b ovr=%b exp 1/1/0", busy, sample_hold, overrun); end
      end
      @(negedge clk);
    end
    idle(2);
  endtask

  task automatic test_overrun;
    logic exp_o;
    ain   = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      exp_o = (k == 6) || (k == 13);
      checks++; if (overrun !== exp_o) begin
        errors++; $display("FAIL ovr_pulse k=%0d got=%b exp=%b", k, overrun, exp_o); end
      checks++; if (adc_valid !== (k == 21)) begin
        errors++; $display("FAIL ovr_valid k=%0d got=%b exp=%b", k, adc_valid, (k == 21)); end
      if (k == 21) begin
        checks++; if (V_ADC !== 8'hA5) begin
          errors++; $display("FAIL ovr_result got=%h exp=A5", V_ADC); end
      end
      if (k == 5 || k == 12) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
    end
    idle(2);
  endtask

  task automatic test_blanking;
    logic exp_sh, exp_b;
    ain     = 8'h96;
    led_sel = ~led_sel;
    @(negedge clk);
    for (int k = 1; k <= 30; k++) begin
      exp_sh = (k >= 9) && (k <= 12);
      exp_b  = (k >= 3) && (k <= 28);
      checks++; if (sample_hold !== exp_sh) begin
        errors++; $display("FAIL blank_sh k=%0d got=%b exp=%b", k, sample_hold, exp_sh); end
      checks++; if (busy !== exp_b) begin
        errors++; $display("FAIL blank_busy k=%0d got=%b exp=%b", k, busy, exp_b); end
      checks++; if (adc_valid !== (k == 29)) begin
        errors++; $display("FAIL blank_valid k=%0d got=%b exp=%b", k, adc_valid, (k == 29)); end
      if (k == 29) begin
        checks++; if (V_ADC !== 8'h96) begin
          errors++; $display("FAIL blank_result got=%h exp=96", V_ADC); end
      end
      start = (k == 2);
      @(negedge clk);
    end
    start = 1'b0;
    idle(2);
  endtask

  task automatic test_abort;
    logic [7:0] v_old;
    ain   = 8'h3C;
    v_old = V_ADC;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      if (k < 42) begin
        checks++; if (adc_valid !== 1'b0 || V_ADC !== v_old) begin
          errors++; $display("FAIL abort_quiet k=%0d valid=%b vadc=%h exp 0/%h", k, adc_valid, V_ADC, v_old); end
      end else begin
        checks++; if (adc_valid !== 1'b1 || V_ADC !== 8'h3C) begin
          errors++; $display("FAIL abort_resume valid=%b vadc=%h exp 1/3C", adc_valid, V_ADC); end
      end
      if (k == 13) begin
        checks++; if (dac_code !== 8'h38) begin
          errors++; $display("FAIL abort_bit3 got=%h exp=38", dac_code); end
        led_sel = ~led_sel;
      end
      if (k == 14) begin
        checks++; if (dac_code !== 8'h00 || busy !== 1'b1 || sample_hold !== 1'b0) begin
          errors++; $display("FAIL abort_state dac=%h busy=%b sh=%b exp 00/1/0", dac_code, busy, sample_hold); end
      end
      if (k >= 15 && k <= 25) begin
        checks++; if (sample_hold !== (k >= 22)) begin
          errors++; $display("FAIL abort_sh k=%0d got=%b exp=%b", k, sample_hold, (k >= 22)); end
      end
      @(negedge clk);
    end
    idle(2);
  endtask

  task automatic test_rst_mid;
    int n_valid;
    ain     = 8'hC3;
    n_valid = 0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 11) begin
        checks++; if (dac_code !== 8'h00 || busy !== 1'b0 || V_ADC !== 8'h00 || adc_valid !== 1'b0 || sample_hold !== 1'b0) begin
          errors++; $display("FAIL rstmid dac=%h busy=%b vadc=%h valid=%b sh=%b exp 00/0/00/0/0", dac_code, busy, V_ADC, adc_valid, sample_hold); end
        rst = 1'b0;
      end
      if (adc_valid === 1'b1) n_valid++;
      if (k == 10) begin
        checks++; if (busy !== 1'b1 || dac_code !== 8'hE0) begin
          errors++; $display("FAIL rstmid_pre busy=%b dac=%h exp 1/E0", busy, dac_code); end
        rst = 1'b1;
      end
      @(negedge clk);
    end
    checks++; if (n_valid != 0) begin
      errors++; $display("FAIL rstmid_strobes got=%0d exp=0", n_valid); end
  endtask

  initial begin
    test_reset;
    test_conversion;
    test_back_to_back;
    test_overrun;
    test_blanking;
    test_abort;
    test_rst_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
